// File: rtl/paddle_pkg.sv
// Shared constants for the paddle command path: UART key codes, paddle_control
// bit positions and the byte classifier used by the arbiter.
package paddle_pkg;

  localparam logic [7:0] CMD_P1_UP = 8'h77;  // 'w'
  localparam logic [7:0] CMD_P1_DN = 8'h73;  // 's'
  localparam logic [7:0] CMD_P2_UP = 8'h69;  // 'i'
  localparam logic [7:0] CMD_P2_DN = 8'h6B;  // 'k'
  localparam logic [7:0] CMD_CLEAR = 8'h78;  // 'x'

  localparam int PC_P1_UP = 0;
  localparam int PC_P1_DN = 1;
  localparam int PC_P2_UP = 2;
  localparam int PC_P2_DN = 3;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    K_NONE,
    K_P1_UP,
    K_P1_DN,
    K_P2_UP,
    K_P2_DN,
    K_CLEAR,
    K_BAD
  } cmd_kind_t;

  function automatic cmd_kind_t decode_cmd(input logic [7:0] b);
    case (b)
      CMD_P1_UP: return K_P1_UP;
      CMD_P1_DN: return K_P1_DN;
      CMD_P2_UP: return K_P2_UP;
      CMD_P2_DN: return K_P2_DN;
      CMD_CLEAR: return K_CLEAR;
      default:   return K_BAD;
    endcase
  endfunction

endpackage

// File: rtl/paddle_cmd_arbiter_hold_counter.sv
// Frame-based hold timer for one remote paddle direction. A reload takes
// priority over a clear and over a same-cycle frame decrement.
module hold_counter
  import paddle_pkg::*;
#(
  parameter int HOLD_FRAMES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  input  logic tick,
  output logic active
);

  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_FRAMES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= HOLD_VAL;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/paddle_cmd_arbiter.sv
// Merges UART paddle commands with local player-1 buttons into a frame-coherent
// paddle_control vector. Define PADDLE_DEBOUNCE_EN to debounce the buttons.
module paddle_cmd_arbiter
  import paddle_pkg::*;
#(
  parameter int HOLD_FRAMES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       frame_tick,
  output logic [3:0] paddle_control,
  output logic       cmd_error,
  output logic       p1_local
);

  // Stage p0: button synchronizers
  logic [SYNC_STAGES-1:0] up_sync_p0;
  logic [SYNC_STAGES-1:0] dn_sync_p0;
  logic [1:0]             btn_sync;   // {down, up}
  logic [1:0]             btn_clean;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sync_p0 <= '0;
      dn_sync_p0 <= '0;
    end else begin
      up_sync_p0 <= {up_sync_p0[SYNC_STAGES-2:0], btn_up};
      dn_sync_p0 <= {dn_sync_p0[SYNC_STAGES-2:0], btn_down};
    end
  end

  assign btn_sync = {dn_sync_p0[SYNC_STAGES-1], up_sync_p0[SYNC_STAGES-1]};

`ifdef PADDLE_DEBOUNCE_EN
  localparam int DB_W = 16;

  logic [1:0]      db_state;
  logic [DB_W-1:0] db_cnt [2];

  // A button changes state only after 2^16 consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] != db_state[i]) begin
          if (db_cnt[i] == '1) begin
            db_state[i] <= btn_sync[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign btn_clean = db_state;
`else
  assign btn_clean = btn_sync;
`endif

  // Command decode and hold counters
  cmd_kind_t  kind;
  logic [3:0] load;
  logic [3:0] clear;
  logic [3:0] active;

  always_comb begin
    kind  = rx_valid ? decode_cmd(rx_data) : K_NONE;
    load  = '0;
    clear = '0;
    case (kind)
      K_P1_UP: begin
        load[PC_P1_UP]  = 1'b1;
        clear[PC_P1_DN] = 1'b1;
      end
      K_P1_DN: begin
        load[PC_P1_DN]  = 1'b1;
        clear[PC_P1_UP] = 1'b1;
      end
      K_P2_UP: begin
        load[PC_P2_UP]  = 1'b1;
        clear[PC_P2_DN] = 1'b1;
      end
      K_P2_DN: begin
        load[PC_P2_DN]  = 1'b1;
        clear[PC_P2_UP] = 1'b1;
      end
      K_CLEAR: clear = '1;
      default: ;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_hold
    hold_counter #(
      .HOLD_FRAMES(HOLD_FRAMES)
    ) u_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[g]),
      .clear (clear[g]),
      .tick  (frame_tick),
      .active(active[g])
    );
  end

  // Player arbitration from pre-update counters
  logic       local_sel;
  logic       p1_up;
  logic       p1_dn;
  logic       p2_up;
  logic       p2_dn;
  logic [3:0] pc_next;

  always_comb begin
    local_sel = btn_clean[0] | btn_clean[1];
    if (local_sel) begin
      p1_up = btn_clean[0];
      p1_dn = btn_clean[1];
    end else begin
      p1_up = active[PC_P1_UP];
      p1_dn = active[PC_P1_DN];
    end
    if (p1_up && p1_dn) begin
      p1_up = 1'b0;
      p1_dn = 1'b0;
    end
    p2_up = active[PC_P2_UP];
    p2_dn = active[PC_P2_DN];
    if (p2_up && p2_dn) begin
      p2_up = 1'b0;
      p2_dn = 1'b0;
    end
    pc_next           = '0;
    pc_next[PC_P1_UP] = p1_up;
    pc_next[PC_P1_DN] = p1_dn;
    pc_next[PC_P2_UP] = p2_up;
    pc_next[PC_P2_DN] = p2_dn;
  end

  // Stage p1: frame-aligned output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddle_control <= '0;
      p1_local       <= 1'b0;
      cmd_error      <= 1'b0;
    end else begin
      cmd_error <= (kind == K_BAD);
      if (frame_tick) begin
        paddle_control <= pc_next;
        p1_local       <= local_sel;
      end
    end
  end

endmodule

// File: tb/tb_paddle_cmd_arbiter.sv
// Self-checking bench for paddle_cmd_arbiter (HOLD_FRAMES=3): directed scenarios
// plus randomized traffic compared with a frame-level reference model.
module tb_paddle_cmd_arbiter;

  localparam int HOLD = 3;
  localparam int SS   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       btn_up;
  logic       btn_down;
  logic       frame_tick;
  logic [3:0] paddle_control;
  logic       cmd_error;
  logic       p1_local;

  int errors = 0;
  int checks = 0;

  // reference model state: remaining hold frames per direction
  int   m_cnt [4];  // 0=p1 up, 1=p1 down, 2=p2 up, 3=p2 down
  logic [3:0] m_pc;
  logic m_loc;
  logic m_err;
  logic m_up_h[$];
  logic m_dn_h[$];
  logic cur_up;
  logic cur_dn;

  paddle_cmd_arbiter #(
    .HOLD_FRAMES(HOLD),
    .SYNC_STAGES(SS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .frame_tick    (frame_tick),
    .paddle_control(paddle_control),
    .cmd_error     (cmd_error),
    .p1_local      (p1_local)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_pc  = 4'b0000;
    m_loc = 1'b0;
    m_err = 1'b0;
    m_up_h.delete();
    m_dn_h.delete();
    for (int i = 0; i < SS; i++) begin
      m_up_h.push_back(1'b0);
      m_dn_h.push_back(1'b0);
    end
  endtask

  // One clock cycle of stimulus; the model advances alongside the DUT.
  task automatic step(input logic v, input logic [7:0] d, input logic t);
    logic su, sd, a1u, a1d, a2u, a2d;
    @(negedge clk);
    rx_valid   = v;
    rx_data    = d;
    btn_up     = cur_up;
    btn_down   = cur_dn;
    frame_tick = t;
    @(posedge clk);
    su = m_up_h.pop_front();
    sd = m_dn_h.pop_front();
    m_up_h.push_back(cur_up);
    m_dn_h.push_back(cur_dn);
    if (t) begin
      if (su || sd) begin
        a1u = su; a1d = sd; m_loc = 1'b1;
      end else begin
        a1u = (m_cnt[0] > 0); a1d = (m_cnt[1] > 0); m_loc = 1'b0;
      end
      if (a1u && a1d) begin a1u = 1'b0; a1d = 1'b0; end
      a2u = (m_cnt[2] > 0);
      a2d = (m_cnt[3] > 0);
      if (a2u && a2d) begin a2u = 1'b0; a2d = 1'b0; end
      m_pc = {a2d, a2u, a1d, a1u};
      for (int i = 0; i < 4; i++) if (m_cnt[i] > 0) m_cnt[i]--;
    end
    m_err = 1'b0;
    if (v) begin
      case (d)
        8'h77: begin m_cnt[0] = HOLD; m_cnt[1] = 0; end
        8'h73: begin m_cnt[1] = HOLD; m_cnt[0] = 0; end
        8'h69: begin m_cnt[2] = HOLD; m_cnt[3] = 0; end
        8'h6B: begin m_cnt[3] = HOLD; m_cnt[2] = 0; end
        8'h78: for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        default: m_err = 1'b1;
      endcase
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; frame_tick = 1'b0;
    cur_up = 1'b0; cur_dn = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({paddle_control, cmd_error, p1_local} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b expected %b", {paddle_control, cmd_error, p1_local}, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(2);
      tick();
      checks++;
      if (paddle_control !== 4'b0000 || p1_local !== 1'b0) begin
        errors++;
        $display("FAIL idle_tick%0d: pc=%b loc=%b expected 0000 0", i + 1, paddle_control, p1_local);
      end
    end
  endtask

  task automatic test_p2_hold();
    logic [3:0] exp;
    do_reset();
    send(8'h69);
    idle(1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp = (i <= 3) ? 4'b0100 : 4'b0000;
      checks++;
      if (paddle_control !== exp) begin
        errors++;
        $display("FAIL p2_hold tick%0d: pc=%b expected %b", i, paddle_control, exp);
      end
    end
  endtask

  task automatic test_last_byte_wins();
    do_reset();
    send(8'h77);
    send(8'h73);
    tick();
    checks++;
    if (paddle_control !== 4'b0010) begin
      errors++;
      $display("FAIL last_byte_wins: pc=%b expected %b", paddle_control, 4'b0010);
    end
  endtask

  task automatic test_local_override();
    do_reset();
    send(8'h73);
    tick();
    cur_up = 1'b1;
    idle(3);
    tick();
    checks++;
    if (paddle_control !== 4'b0001 || p1_local !== 1'b1) begin
      errors++;
      $display("FAIL local_override: pc=%b loc=%b expected 0001 1", paddle_control, p1_local);
    end
    cur_up = 1'b0;
    idle(3);
    tick();
    checks++;
    if (paddle_control !== 4'b0010 || p1_local !== 1'b0) begin
      errors++;
      $display("FAIL local_release: pc=%b loc=%b expected 0010 0", paddle_control, p1_local);
    end
    cur_up = 1'b1; cur_dn = 1'b1;
    idle(3);
    tick();
    checks++;
    if (paddle_control !== 4'b0000 || p1_local !== 1'b1) begin
      errors++;
      $display("FAIL local_conflict: pc=%b loc=%b expected 0000 1", paddle_control, p1_local);
    end
    cur_up = 1'b0; cur_dn = 1'b0;
  endtask

  task automatic test_bad_byte();
    do_reset();
    send(8'h69);
    checks++;
    if (cmd_error !== 1'b0) begin
      errors++;
      $display("FAIL good_byte_err: cmd_error=%b expected 0", cmd_error);
    end
    tick();
    send(8'h41);
    checks++;
    if (cmd_error !== 1'b1) begin
      errors++;
      $display("FAIL bad_byte_err: cmd_error=%b expected 1", cmd_error);
    end
    idle(1);
    checks++;
    if (cmd_error !== 1'b0) begin
      errors++;
      $display("FAIL bad_byte_pulse: cmd_error=%b expected 0", cmd_error);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (paddle_control !== ((i <= 2) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL bad_byte_hold tick%0d: pc=%b expected %b", i, paddle_control,
                 (i <= 2) ? 4'b0100 : 4'b0000);
      end
    end
  endtask

  task automatic test_reload_on_tick();
    do_reset();
    send(8'h6B);
    tick();
    step(1'b1, 8'h6B, 1'b1);
    checks++;
    if (paddle_control !== 4'b1000) begin
      errors++;
      $display("FAIL reload_tick_out: pc=%b expected %b", paddle_control, 4'b1000);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (paddle_control !== ((i <= 3) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL reload_hold tick%0d: pc=%b expected %b", i, paddle_control,
                 (i <= 3) ? 4'b1000 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    send(8'h6B);
    tick();
    cur_up = 1'b1;
    idle(3);
    tick();
    checks++;
    if (paddle_control !== 4'b1001) begin
      errors++;
      $display("FAIL pre_reset: pc=%b expected %b", paddle_control, 4'b1001);
    end
    send(8'h41);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({paddle_control, cmd_error, p1_local} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset: outputs=%b expected %b", {paddle_control, cmd_error, p1_local}, 6'b0);
    end
    do_reset();
    tick();
    checks++;
    if (paddle_control !== 4'b0000 || p1_local !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_tick: pc=%b loc=%b expected 0000 0", paddle_control, p1_local);
    end
  endtask

  task automatic test_random();
    logic [7:0] codes [6];
    logic       v, t;
    logic [7:0] d;
    codes[0] = 8'h77; codes[1] = 8'h73; codes[2] = 8'h69;
    codes[3] = 8'h6B; codes[4] = 8'h78; codes[5] = 8'h00;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) cur_up = ~cur_up;
      if ($urandom_range(0, 19) == 0) cur_dn = ~cur_dn;
      v = ($urandom_range(0, 4) == 0);
      d = codes[$urandom_range(0, 5)];
      if (d == 8'h00) d = 8'($urandom);
      t = ($urandom_range(0, 7) == 0);
      step(v, d, t);
      checks++;
      if (paddle_control !== m_pc || p1_local !== m_loc || cmd_error !== m_err) begin
        errors++;
        $display("FAIL random cycle%0d: pc=%b loc=%b err=%b expected %b %b %b",
                 n, paddle_control, p1_local, cmd_error, m_pc, m_loc, m_err);
      end
    end
    cur_up = 1'b0; cur_dn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; frame_tick = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0;
    cur_up = 1'b0; cur_dn = 1'b0;
    model_reset();
    test_reset();
    test_p2_hold();
    test_last_byte_wins();
    test_local_override();
    test_bad_byte();
    test_reload_on_tick();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/paddle_cmd_arbiter.md
Name: paddle_cmd_arbiter

Overview:
- Sits between the UART receiver and the VGA game engine.
- Merges the remote key bytes received over UART with the local player-1 pushbuttons into the 4-bit paddle_control vector the game consumes.
- UART delivers only key-press events, never key releases, so each remote command is held for a fixed number of video frames.
- The output is updated once per frame so paddle motion stays frame-coherent.

Parameters:
- HOLD_FRAMES, 4: frames a remote command stays asserted after its last byte; legal range 1..255.
- SYNC_STAGES, 2: flip-flop stages on the asynchronous button inputs; minimum 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received UART byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle strobe for rx_data.
- btn_up  in  1  player-1 local up button; asynchronous.
- btn_down  in  1  player-1 local down button; asynchronous.
- frame_tick  in  1  one-cycle pulse per frame (from vsync edge).
- paddle_control  out  4  {p2_down, p2_up, p1_down, p1_up}; registered.
- cmd_error  out  1  one-cycle pulse when an unrecognised byte is received.
- p1_local  out  1  high when player 1 is driven by the local buttons in the current frame; registered.

Behaviour:
- Reset (async assert, sync release): paddle_control=0, cmd_error=0, p1_local=0, all hold counters=0, sync flops=0.
- Buttons pass through SYNC_STAGES flops before use.
- Four hold counters, 8 bits each: c_p1u, c_p1d, c_p2u, c_p2d. Remote direction active = counter != 0.
- Byte decode, applied on the rx_valid cycle, effective next cycle:
  - 0x77 'w': c_p1u=HOLD_FRAMES, c_p1d=0.
  - 0x73 's': c_p1d=HOLD_FRAMES, c_p1u=0.
  - 0x69 'i': c_p2u=HOLD_FRAMES, c_p2d=0.
  - 0x6B 'k': c_p2d=HOLD_FRAMES, c_p2u=0.
  - 0x78 'x': all four counters=0.
  - Any other value: counters unchanged; cmd_error=1 on the following cycle only.
- Counter decrement: on frame_tick, each nonzero counter decrements by 1; a zero counter stays 0 (no wrap).
- Reload and frame_tick in the same cycle: the reload wins for the addressed counters (result = HOLD_FRAMES, no decrement). Other counters still decrement.
- Player-1 arbitration:
  - If either synchronized button is high, local wins: p1_up=btn_up, p1_down=btn_down, p1_local=1.
  - Otherwise remote drives player 1: p1_up=(c_p1u!=0), p1_down=(c_p1d!=0), p1_local=0.
- Player 2 is remote only.
- Conflict: if up and down are both requested for one player (only possible from the local buttons), both are forced to 0.
- Output update: paddle_control and p1_local load only on frame_tick cycles, from the arbitration of pre-update counter values and current sync outputs. They hold between ticks.
- Latency: a byte accepted at cycle t is visible the cycle after the first frame_tick at or after t+1. A remote hold then lasts exactly HOLD_FRAMES frames.
- Reset mid-frame clears everything immediately. The first tick after release outputs 0 unless new input has arrived.

Optional Feature:
- Macro: PADDLE_DEBOUNCE_EN.
- Defined: each synchronized button passes through a debouncer that changes state only after the input has been stable for 2^16 consecutive clk cycles. Debounce state resets to 0.
- Undefined: the synchronized buttons are used directly; no debounce logic is synthesized.

Decomposition:
- Shared package paddle_pkg:
  - command byte constants CMD_P1_UP, CMD_P1_DN, CMD_P2_UP, CMD_P2_DN, CMD_CLEAR;
  - paddle_control bit-index constants PC_P1_UP=0, PC_P1_DN=1, PC_P2_UP=2, PC_P2_DN=3.
- One sub-module, hold_counter: load, clear and tick inputs, active output; instantiated four times.

Test Plan (HOLD_FRAMES=3):
- Reset, then tick 5 frames with no input -> paddle_control=4'b0000, p1_local=0 throughout.
- rx 0x69, then 4 ticks -> paddle_control=4'b0100 after ticks 1-3; 4'b0000 after tick 4.
- rx 0x77, then rx 0x73 before the next tick, then tick -> paddle_control=4'b0010 (last byte wins, opposite direction cleared).
- btn_up held while c_p1d active, then tick -> paddle_control[1:0]=2'b01, p1_local=1. Release btn_up, then tick -> 2'b10, p1_local=0.
- rx 0x41 -> cmd_error high for exactly 1 cycle; counters unchanged.
- rx 0x6B coinciding with frame_tick -> c_p2d=3 (no decrement). Assert rst_n=0 mid-hold -> all outputs 0 immediately.
